instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns a mnemonic plus fields into a 32-bit word and
// hands it downstream through a single registered valid/ready stage with a word address.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic              err
);

    localparam logic [3:0] M_ADD  = 4'd0;
    localparam logic [3:0] M_SUB  = 4'd1;
    localparam logic [3:0] M_AND  = 4'd2;
    localparam logic [3:0] M_OR   = 4'd3;
    localparam logic [3:0] M_SLT  = 4'd4;
    localparam logic [3:0] M_NOR  = 4'd5;
    localparam logic [3:0] M_LW   = 4'd6;
    localparam logic [3:0] M_SW   = 4'd7;
    localparam logic [3:0] M_BEQ  = 4'd8;
    localparam logic [3:0] M_ADDI = 4'd9;
    localparam logic [3:0] M_LUI  = 4'd10;
    localparam logic [3:0] M_ORI  = 4'd11;
    localparam logic [3:0] M_ANDI = 4'd12;
    localparam logic [3:0] M_J    = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    logic [31:0]       enc_c;
    logic              legal_c;
    logic              req_xfer_c;
    logic              out_xfer_c;

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              err_q,   err_d;

    // Field packing per instruction format; unused fields are simply not referenced.
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (mnem)
            M_ADD:   enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            M_SUB:   enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            M_AND:   enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            M_OR:    enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            M_SLT:   enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            M_NOR:   enc_c = {OP_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
            M_LW:    enc_c = {OP_LW,   rs, rt, imm};
            M_SW:    enc_c = {OP_SW,   rs, rt, imm};
            M_BEQ:   enc_c = {OP_BEQ,  rs, rt, imm};
            M_ADDI:  enc_c = {OP_ADDI, rs, rt, imm};
            M_LUI:   enc_c = {OP_LUI,  5'd0, rt, imm};
            M_ORI:   enc_c = {OP_ORI,  rs, rt, imm};
            M_ANDI:  enc_c = {OP_ANDI, rs, rt, imm};
            M_J:     enc_c = {OP_J, target};
            default: legal_c = 1'b0;
        endcase
    end

    assign in_ready   = !valid_q || out_ready;
    assign req_xfer_c = in_valid && in_ready;
    assign out_xfer_c = valid_q && out_ready;

    // Drain first, then load; a same-cycle legal load keeps valid high at the bumped address.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (out_xfer_c) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + ADDR_W'(1);
        end
        if (req_xfer_c) begin
            if (legal_c) begin
                valid_d = 1'b1;
                instr_d = enc_c;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign instr     = instr_q;
    assign addr      = cnt_q;
    assign err       = err_q;

endmodule
